tc_fetch_unit: RTL and testbench

Instruction fetch sequencer that sits directly upstream of the 4-byte program memory and also consumes its output. It drives the memory byte address and captures the 4 returned bytes one cycle later. Captured words are buffered and handed to decode as a 32-bit instruction plus its PC over a valid/ready handshake. Handles sequential fetch, jump redirect with flush, halt, and backpressure.

---
 rtl/tc_fetch_pkg.sv | 10 +
 rtl/tc_fetch_fifo.sv | 45 ++++
 rtl/tc_fetch_unit.sv | 88 ++++++++
 tb/tb_tc_fetch_unit.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/tc_fetch_pkg.sv
// tc_fetch_pkg: shared fetch-unit defaults and buffered instruction record type
package tc_fetch_pkg;
  localparam int DEFAULT_ADDR_W = 16;
  localparam int DEFAULT_INSTR_BYTES = 4;
  localparam logic [DEFAULT_ADDR_W-1:0] DEFAULT_RESET_PC = 16'h0000;
  typedef struct packed {
    logic [31:0] word;
    logic [DEFAULT_ADDR_W-1:0] pc;
  } inst_t;
endpackage

// File: rtl/tc_fetch_fifo.sv
// tc_fetch_fifo: sync FIFO with flush, simultaneous push/pop and occupancy (rst active-low)
module tc_fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 48
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic pop,
  input  logic flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic valid,
  output logic [$clog2(DEPTH):0] occ
);
  localparam int PW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [PW:0] occ_q, occ_d;
  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wr_q] = din;
    rd_d = flush ? '0 : rd_q + PW'(pop);
    wr_d = flush ? '0 : wr_q + PW'(push);
    occ_d = flush ? '0 : occ_q + (PW+1)'(push) - (PW+1)'(pop);
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      mem_q <= '{default: '0};
      rd_q <= '0;
      wr_q <= '0;
      occ_q <= '0;
    end else begin
      mem_q <= mem_d;
      rd_q <= rd_d;
      wr_q <= wr_d;
      occ_q <= occ_d;
    end
  end
  assign dout = mem_q[rd_q];
  assign valid = occ_q != '0;
  assign occ = occ_q;
  assert property (@(posedge clk) disable iff (!rst) (push && !pop && !flush) |-> (occ_q < (PW+1)'(DEPTH)));
endmodule

// File: rtl/tc_fetch_unit.sv
// tc_fetch_unit: credit-based instruction fetch sequencer; TC_FETCH_PERF_EN adds perf counters
module tc_fetch_unit
  import tc_fetch_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC),
  parameter int INSTR_BYTES = DEFAULT_INSTR_BYTES,
  parameter int FIFO_DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  output logic [ADDR_W-1:0] address,
  input  logic [7:0] mem0,
  input  logic [7:0] mem1,
  input  logic [7:0] mem2,
  input  logic [7:0] mem3,
  input  logic halt,
  input  logic jump_valid,
  input  logic [ADDR_W-1:0] jump_target,
  output logic inst_valid,
  input  logic inst_ready,
  output logic [31:0] inst,
  output logic [ADDR_W-1:0] inst_pc
`ifdef TC_FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_flushed
`endif
);
  localparam int CW = $clog2(FIFO_DEPTH) + 2;
  logic [ADDR_W-1:0] pc_q, pc_d, inflight_pc_q, inflight_pc_d;
  logic inflight_q, inflight_d, pop, push, issue;
  logic [CW-2:0] occ;
  logic [CW-1:0] used;
  always_comb begin
    address = !rst ? RESET_PC : jump_valid ? jump_target : pc_q;
    pop = inst_valid && inst_ready;
    push = inflight_q && !jump_valid;
    used = jump_valid ? '0 : CW'(occ) + CW'(inflight_q) - CW'(pop);
    issue = !halt && (used < CW'(FIFO_DEPTH));
    inflight_d = issue;
    inflight_pc_d = issue ? address : inflight_pc_q;
    pc_d = issue ? address + ADDR_W'(INSTR_BYTES) : address;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q <= RESET_PC;
      inflight_q <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      pc_q <= pc_d;
      inflight_q <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
    end
  end
  tc_fetch_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(32 + ADDR_W)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(push),
    .pop(pop),
    .flush(jump_valid),
    .din({mem3, mem2, mem1, mem0, inflight_pc_q}),
    .dout({inst, inst_pc}),
    .valid(inst_valid),
    .occ(occ)
  );
`ifdef TC_FETCH_PERF_EN
  logic [31:0] perf_fetched_q, perf_fetched_d, perf_flushed_q, perf_flushed_d;
  logic [32:0] fetched_sum, flushed_sum;
  always_comb begin
    fetched_sum = {1'b0, perf_fetched_q} + 33'(push);
    flushed_sum = {1'b0, perf_flushed_q} + (jump_valid ? 33'(occ) - 33'(pop) + 33'(inflight_q) : 33'd0);
    perf_fetched_d = fetched_sum[32] ? '1 : fetched_sum[31:0];
    perf_flushed_d = flushed_sum[32] ? '1 : flushed_sum[31:0];
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      perf_fetched_q <= '0;
      perf_flushed_q <= '0;
    end else begin
      perf_fetched_q <= perf_fetched_d;
      perf_flushed_q <= perf_flushed_d;
    end
  end
  assign perf_fetched = perf_fetched_q;
  assign perf_flushed = perf_flushed_q;
`endif
endmodule

// File: tb/tb_tc_fetch_unit.sv
// tb_tc_fetch_unit: table-driven check of tc_fetch_unit against a patterned program memory
module tb_tc_fetch_unit;
  import tc_fetch_pkg::*;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, halt, jump_valid, inst_ready, inst_valid;
  logic [15:0] jump_target, address, inst_pc;
  logic [7:0] mem0, mem1, mem2, mem3;
  logic [31:0] inst;
  logic rst2, inst_valid2;
  logic [15:0] address2, inst_pc2;
  logic [7:0] m20, m21, m22, m23;
  logic [31:0] inst2;
`ifdef TC_FETCH_PERF_EN
  logic [31:0] perf_fetched, perf_flushed, pf2, pl2;
`endif
  int n_run = 0;
  int n_fail = 0;
  tc_fetch_unit dut (
    .clk(clk), .rst(rst), .address(address),
    .mem0(mem0), .mem1(mem1), .mem2(mem2), .mem3(mem3),
    .halt(halt), .jump_valid(jump_valid), .jump_target(jump_target),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc)
`ifdef TC_FETCH_PERF_EN
    , .perf_fetched(perf_fetched), .perf_flushed(perf_flushed)
`endif
  );
  tc_fetch_unit #(.RESET_PC(16'hFFF8)) dut2 (
    .clk(clk), .rst(rst2), .address(address2),
    .mem0(m20), .mem1(m21), .mem2(m22), .mem3(m23),
    .halt(1'b0), .jump_valid(1'b0), .jump_target(16'h0000),
    .inst_valid(inst_valid2), .inst_ready(1'b1), .inst(inst2), .inst_pc(inst_pc2)
`ifdef TC_FETCH_PERF_EN
    , .perf_fetched(pf2), .perf_flushed(pl2)
`endif
  );
  function automatic logic [7:0] mem_byte(input logic [15:0] a);
    return a[7:0] + a[15:8] + 8'd1;
  endfunction
  always @(posedge clk) begin
    mem0 <= mem_byte(address);
    mem1 <= mem_byte(address + 16'd1);
    mem2 <= mem_byte(address + 16'd2);
    mem3 <= mem_byte(address + 16'd3);
    m20 <= mem_byte(address2);
    m21 <= mem_byte(address2 + 16'd1);
    m22 <= mem_byte(address2 + 16'd2);
    m23 <= mem_byte(address2 + 16'd3);
  end
  typedef struct {
    logic r, h, j, rdy;
    logic [15:0] jt;
    logic v, d;
    inst_t e;
    logic [15:0] a;
  } vec_t;
  function automatic vec_t mk(input logic r, h, j, rdy, input logic [15:0] jt, input logic v, d,
                              input logic [31:0] w, input logic [15:0] p, a);
    vec_t t;
    t.r = r; t.h = h; t.j = j; t.rdy = rdy; t.jt = jt; t.v = v; t.d = d;
    t.e.word = w; t.e.pc = p; t.a = a;
    return t;
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  vec_t vt[34];
  initial begin
    vt[0]  = mk(0,0,0,1,16'h0000, 0,1, 32'h0, 16'h0000, 16'h0000);
    vt[1]  = mk(1,0,0,1,16'h0000, 0,1, 32'h0, 16'h0000, 16'h0000);
    vt[2]  = mk(1,0,0,1,16'h0000, 0,1, 32'h0, 16'h0000, 16'h0004);
    vt[3]  = mk(1,0,0,1,16'h0000, 1,1, 32'h04030201, 16'h0000, 16'h0008);
    vt[4]  = mk(1,0,0,1,16'h0000, 1,1, 32'h08070605, 16'h0004, 16'h000C);
    vt[5]  = mk(1,0,0,1,16'h0000, 1,1, 32'h0C0B0A09, 16'h0008, 16'h0010);
    vt[6]  = mk(0,0,0,0,16'h0000, 1,1, 32'h100F0E0D, 16'h000C, 16'h0000);
    vt[7]  = mk(0,0,0,0,16'h0000, 0,1, 32'h0, 16'h0000, 16'h0000);
    vt[8]  = mk(1,0,0,0,16'h0000, 0,1, 32'h0, 16'h0000, 16'h0000);
    vt[9]  = mk(1,0,0,0,16'h0000, 0,1, 32'h0, 16'h0000, 16'h0004);
    for (int i = 10; i < 15; i++) vt[i] = mk(1,0,0,0,16'h0000, 1,1, 32'h04030201, 16'h0000, 16'h0008);
    vt[15] = mk(1,0,0,1,16'h0000, 1,1, 32'h04030201, 16'h0000, 16'h0008);
    vt[16] = mk(1,0,0,1,16'h0000, 1,1, 32'h08070605, 16'h0004, 16'h000C);
    vt[17] = mk(1,0,0,0,16'h0000, 1,1, 32'h0C0B0A09, 16'h0008, 16'h0010);
    vt[18] = mk(0,0,0,0,16'h0000, 1,1, 32'h0C0B0A09, 16'h0008, 16'h0000);
    vt[19] = mk(1,0,0,1,16'h0000, 0,1, 32'h0, 16'h0000, 16'h0000);
    vt[20] = mk(1,0,0,1,16'h0000, 0,1, 32'h0, 16'h0000, 16'h0004);
    vt[21] = mk(1,0,0,1,16'h0000, 1,1, 32'h04030201, 16'h0000, 16'h0008);
    vt[22] = mk(1,0,1,1,16'h0100, 1,1, 32'h08070605, 16'h0004, 16'h0100);
    vt[23] = mk(1,0,0,1,16'h0000, 0,0, 32'h0, 16'h0000, 16'h0104);
    vt[24] = mk(1,0,0,1,16'h0000, 1,1, 32'h05040302, 16'h0100, 16'h0108);
    vt[25] = mk(1,1,0,1,16'h0000, 1,1, 32'h09080706, 16'h0104, 16'h010C);
    vt[26] = mk(1,1,0,1,16'h0000, 1,1, 32'h0D0C0B0A, 16'h0108, 16'h010C);
    vt[27] = mk(1,1,0,1,16'h0000, 0,0, 32'h0, 16'h0000, 16'h010C);
    vt[28] = mk(1,0,0,1,16'h0000, 0,0, 32'h0, 16'h0000, 16'h010C);
    vt[29] = mk(1,0,0,1,16'h0000, 0,0, 32'h0, 16'h0000, 16'h0110);
    vt[30] = mk(1,0,1,1,16'h0200, 1,1, 32'h11100F0E, 16'h010C, 16'h0200);
    vt[31] = mk(1,0,1,1,16'h0300, 0,0, 32'h0, 16'h0000, 16'h0300);
    vt[32] = mk(1,0,0,1,16'h0000, 0,0, 32'h0, 16'h0000, 16'h0304);
    vt[33] = mk(1,0,0,1,16'h0000, 1,1, 32'h07060504, 16'h0300, 16'h0308);
    rst = 1'b0; rst2 = 1'b0; halt = 1'b0; jump_valid = 1'b0; inst_ready = 1'b1; jump_target = '0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 34; i++) begin
      rst = vt[i].r; halt = vt[i].h; jump_valid = vt[i].j; inst_ready = vt[i].rdy; jump_target = vt[i].jt;
      @(negedge clk);
      chk($sformatf("r%0d valid", i), 32'(inst_valid), 32'(vt[i].v));
      chk($sformatf("r%0d address", i), 32'(address), 32'(vt[i].a));
      if (vt[i].d) begin
        chk($sformatf("r%0d inst", i), inst, vt[i].e.word);
        chk($sformatf("r%0d inst_pc", i), 32'(inst_pc), 32'(vt[i].e.pc));
      end
      @(posedge clk);
      #1;
    end
    rst = 1'b0; halt = 1'b0; jump_valid = 1'b0; inst_ready = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("flush reset valid", 32'(inst_valid), 32'd0);
`ifdef TC_FETCH_PERF_EN
    chk("perf_fetched reset", perf_fetched, 32'd0);
    chk("perf_flushed reset", perf_flushed, 32'd0);
`endif
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    jump_valid = 1'b1; jump_target = 16'h0040;
    @(negedge clk);
    chk("full valid", 32'(inst_valid), 32'd1);
    chk("full inst", inst, 32'h04030201);
    chk("full jump address", 32'(address), 32'h0040);
`ifdef TC_FETCH_PERF_EN
    chk("perf_fetched full", perf_fetched, 32'd2);
    chk("perf_flushed before", perf_flushed, 32'd0);
`endif
    @(posedge clk);
    #1;
    jump_valid = 1'b0; inst_ready = 1'b1;
    @(negedge clk);
    chk("post-flush valid", 32'(inst_valid), 32'd0);
    chk("post-flush address", 32'(address), 32'h0044);
`ifdef TC_FETCH_PERF_EN
    chk("perf_flushed full", perf_flushed, 32'd2);
    chk("perf_fetched hold", perf_fetched, 32'd2);
`endif
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("target valid", 32'(inst_valid), 32'd1);
    chk("target inst", inst, 32'h44434241);
    chk("target inst_pc", 32'(inst_pc), 32'h0040);
`ifdef TC_FETCH_PERF_EN
    chk("perf_fetched after", perf_fetched, 32'd3);
`endif
    @(posedge clk);
    #1;
    rst2 = 1'b1;
    @(negedge clk);
    chk("wrap c0 valid", 32'(inst_valid2), 32'd0);
    chk("wrap c0 address", 32'(address2), 32'hFFF8);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("wrap c1 address", 32'(address2), 32'hFFFC);
    chk("wrap c1 valid", 32'(inst_valid2), 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      @(negedge clk);
      chk($sformatf("wrap c%0d valid", k + 2), 32'(inst_valid2), 32'd1);
      chk($sformatf("wrap c%0d inst", k + 2), inst2, k == 0 ? 32'hFBFAF9F8 : k == 1 ? 32'hFFFEFDFC : 32'h04030201);
      chk($sformatf("wrap c%0d inst_pc", k + 2), 32'(inst_pc2), k == 0 ? 32'hFFF8 : k == 1 ? 32'hFFFC : 32'h0000);
      chk($sformatf("wrap c%0d address", k + 2), 32'(address2), 32'(16'h0000 + 16'(k * 4)));
    end
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
